if_stage_ctrl: RTL and testbench
================================

// Module: if_stage_ctrl
// PURPOSE
//  Fetch-side consumer of the hazard unit's PCWr/IF_ID_Wr stall controls.
//  Owns the PC register and the IF/ID pipeline register, talks to imem via a
//  valid handshake, applies EX-stage redirects (flush) and inserts NOP bubbles.
//  Feeds IF_ID_Rs1/IF_ID_Rs2 back to the hazard detector.
// PARAMETERS
//  RESET_PC   32'h0000_0000   PC value loaded on reset
//  NOP_INST   32'h0000_0013   bubble encoding (addi x0,x0,0)
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   synchronous, active-high reset
//  PCWr         in   1   hazard unit: 1 = PC may advance
//  IF_ID_Wr     in   1   hazard unit: 1 = IF/ID may load
//  flush        in   1   EX: branch taken / jump; redirect to target_pc
//  target_pc    in   32  redirect address (bits [1:0] ignored, forced 0)
//  imem_addr    out  32  fetch address (= pc_q)
//  imem_req     out  1   fetch request
//  imem_rdata   in   32  instruction word for imem_addr
//  imem_valid   in   1   imem_rdata valid this cycle
//  IF_ID_PC     out  32  PC of instruction in IF/ID
//  IF_ID_Inst   out  32  instruction in IF/ID
//  IF_ID_Valid  out  1   1 = real instruction, 0 = bubble
//  IF_ID_Rs1    out  5   IF_ID_Inst[19:15]
//  IF_ID_Rs2    out  5   IF_ID_Inst[24:20]
// BEHAVIOUR
//  - Reset (rst=1 at edge): pc_q=RESET_PC, IF_ID_PC=0, IF_ID_Inst=NOP_INST,
//    IF_ID_Valid=0, state=S_BOOT. imem_req=0 in S_BOOT, 1 in S_RUN/S_MISS.
//  - States: S_BOOT -> S_RUN after one cycle (no fetch accepted in S_BOOT).
//    S_RUN -> S_MISS when imem_req && !imem_valid && !flush;
//    S_MISS -> S_RUN when imem_valid or flush. rst from any state -> S_BOOT.
//  - "take" = state!=S_BOOT && imem_valid && PCWr && IF_ID_Wr && !flush.
//  - Priority per edge: rst > flush > stall > take > bubble.
//  - flush: pc_q<=target_pc&~3; IF/ID<= {PC unchanged, NOP_INST, Valid=0},
//    regardless of PCWr/IF_ID_Wr and of imem_valid; pending fetch discarded.
//  - stall (PCWr=0 && IF_ID_Wr=0): pc_q and IF/ID hold.
//  - take: IF/ID<= {pc_q, imem_rdata, 1}; pc_q<=pc_q+4 (mod 2^32, wraps).
//  - PCWr=0 && IF_ID_Wr=1: IF/ID<=bubble (NOP, Valid=0), pc_q holds.
//  - PCWr=1 && IF_ID_Wr=0: treated as stall (no instruction lost).
//  - Not S_BOOT, PCWr=IF_ID_Wr=1, !imem_valid, !flush: IF/ID<=bubble, pc_q holds.
//  - Fetch-to-IF/ID latency: 1 cycle after imem_valid with take.
//  - IF_ID_Rs1/Rs2 are combinational slices of IF_ID_Inst (0 on bubble NOP).
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds outputs perf_stall_cnt[31:0] (+1 each cycle
//   with stall condition, excluding rst cycles), perf_flush_cnt[31:0] (+1 per
//   flush) and perf_miss_cnt[31:0] (+1 per cycle in S_MISS);
//   all cleared by rst, saturate at 32'hFFFF_FFFF.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  1 rst 2 cycles, imem_valid=1, PCWr=IF_ID_Wr=1 -> cycle after S_BOOT
//    imem_addr=0; next edges IF_ID_PC=0,4,8 with Valid=1.
//  2 PCWr=IF_ID_Wr=0 for 3 cycles at pc_q=0x10 -> pc_q and IF/ID frozen,
//    resumes with IF_ID_PC=0x10 on release.
//  3 flush=1, target_pc=0x103 while stalled -> pc_q=0x100, IF_ID_Inst=
//    32'h13, Valid=0 next edge; following take gives IF_ID_PC=0x100.
//  4 imem_valid=0 for 2 cycles at pc_q=0x20 -> S_MISS, two bubbles, then
//    IF_ID_PC=0x20 Valid=1; pc_q=0x24.
//  5 pc_q=32'hFFFF_FFFC take -> pc_q=0; rst mid-S_MISS -> S_BOOT, pc=RESET_PC.
//  6 FETCH_PERF_CNT_EN: 3 stall cycles + 1 flush -> stall_cnt=3, flush_cnt=1.

Source files
------------

// File: rtl/if_stage_ctrl.sv
// Instruction-fetch stage controller: PC register, IF/ID register, imem handshake,
// redirect and bubble insertion. Optional counters under FETCH_PERF_CNT_EN.
//
//   state  | meaning
//   S_BOOT | first cycle after reset, no fetch request, nothing accepted
//   S_RUN  | fetching, last request answered (or none outstanding)
//   S_MISS | fetching, imem has not yet returned the word for pc_q
module if_stage_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCWr,
    input  logic        IF_ID_Wr,
    input  logic        flush,
    input  logic [31:0] target_pc,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_Inst,
    output logic        IF_ID_Valid,
    output logic [4:0]  IF_ID_Rs1,
    output logic [4:0]  IF_ID_Rs2
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_miss_cnt
`endif
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_MISS = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] if_id_pc_q;
    logic [31:0] if_id_inst_q;
    logic        if_id_valid_q;

    logic        do_flush;
    logic        do_stall;
    logic        do_take;

    // IF_ID_Wr=0 holds everything regardless of PCWr so no fetched word is lost.
    always_comb begin
        do_flush = flush;
        do_stall = !flush && !IF_ID_Wr;
        do_take  = (state_q != S_BOOT) && imem_valid && PCWr && IF_ID_Wr && !flush;
    end

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                imem_req = 1'b1;
                if (!imem_valid && !flush) begin
                    state_d = S_MISS;
                end
            end
            S_MISS: begin
                imem_req = 1'b1;
                if (imem_valid || flush) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            if_id_pc_q    <= 32'h0000_0000;
            if_id_inst_q  <= NOP_INST;
            if_id_valid_q <= 1'b0;
        end else if (do_flush) begin
            pc_q          <= {target_pc[31:2], 2'b00};
            if_id_inst_q  <= NOP_INST;
            if_id_valid_q <= 1'b0;
        end else if (do_stall) begin
            pc_q          <= pc_q;
            if_id_pc_q    <= if_id_pc_q;
            if_id_inst_q  <= if_id_inst_q;
            if_id_valid_q <= if_id_valid_q;
        end else if (do_take) begin
            pc_q          <= pc_q + 32'd4;
            if_id_pc_q    <= pc_q;
            if_id_inst_q  <= imem_rdata;
            if_id_valid_q <= 1'b1;
        end else begin
            // Bubble: PC of the IF/ID slot is left as-is, only the payload is killed.
            if_id_inst_q  <= NOP_INST;
            if_id_valid_q <= 1'b0;
        end
    end

    assign imem_addr   = pc_q;
    assign IF_ID_PC    = if_id_pc_q;
    assign IF_ID_Inst  = if_id_inst_q;
    assign IF_ID_Valid = if_id_valid_q;
    assign IF_ID_Rs1   = if_id_inst_q[19:15];
    assign IF_ID_Rs2   = if_id_inst_q[24:20];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'h0000_0000;
            flush_cnt_q <= 32'h0000_0000;
            miss_cnt_q  <= 32'h0000_0000;
        end else begin
            if (do_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (do_flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
            if ((state_q == S_MISS) && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
    assign perf_miss_cnt  = miss_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Directed bench for if_stage_ctrl: fetch, stall, flush, miss, wrap and reset;
// counter checks when built with FETCH_PERF_CNT_EN.
module tb_if_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCWr;
    logic        IF_ID_Wr;
    logic        flush;
    logic [31:0] target_pc;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_Inst;
    logic        IF_ID_Valid;
    logic [4:0]  IF_ID_Rs1;
    logic [4:0]  IF_ID_Rs2;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
    logic [31:0] perf_miss_cnt;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    // imem returns a word derived from the address so each slot is distinguishable.
    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    assign imem_rdata = inst_of(imem_addr);

    if_stage_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .PCWr        (PCWr),
        .IF_ID_Wr    (IF_ID_Wr),
        .flush       (flush),
        .target_pc   (target_pc),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .IF_ID_PC    (IF_ID_PC),
        .IF_ID_Inst  (IF_ID_Inst),
        .IF_ID_Valid (IF_ID_Valid),
        .IF_ID_Rs1   (IF_ID_Rs1),
        .IF_ID_Rs2   (IF_ID_Rs2)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt),
        .perf_miss_cnt  (perf_miss_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full IF/ID + fetch address check; instruction expected from the bench's imem model.
    task automatic chk_real(input string tag, input logic [31:0] pc, input logic [31:0] addr);
        logic [31:0] ei;
        ei = inst_of(pc);
        chk({tag, "_pc"},    IF_ID_PC, pc);
        chk({tag, "_inst"},  IF_ID_Inst, ei);
        chk({tag, "_valid"}, {31'd0, IF_ID_Valid}, 32'd1);
        chk({tag, "_rs1"},   {27'd0, IF_ID_Rs1}, {27'd0, ei[19:15]});
        chk({tag, "_rs2"},   {27'd0, IF_ID_Rs2}, {27'd0, ei[24:20]});
        chk({tag, "_addr"},  imem_addr, addr);
    endtask

    task automatic chk_bubble(input string tag, input logic [31:0] addr);
        chk({tag, "_inst"},  IF_ID_Inst, NOP);
        chk({tag, "_valid"}, {31'd0, IF_ID_Valid}, 32'd0);
        chk({tag, "_rs1"},   {27'd0, IF_ID_Rs1}, 32'd0);
        chk({tag, "_rs2"},   {27'd0, IF_ID_Rs2}, 32'd0);
        chk({tag, "_addr"},  imem_addr, addr);
    endtask

    initial begin
        rst = 1'b1; PCWr = 1'b1; IF_ID_Wr = 1'b1; flush = 1'b0;
        target_pc = 32'h0; imem_valid = 1'b1;

        // 1: reset then straight-line fetch
        step(); step();
        chk_bubble("rst", 32'h0);
        chk("rst_ifpc", IF_ID_PC, 32'h0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        rst = 1'b0;
        step();
        chk_bubble("boot", 32'h0);
        chk("boot_req", {31'd0, imem_req}, 32'd1);
        step(); chk_real("f0", 32'h0, 32'h4);
        step(); chk_real("f4", 32'h4, 32'h8);
        step(); chk_real("f8", 32'h8, 32'hC);
        step(); chk_real("fc", 32'hC, 32'h10);

        // 2: full stall for three cycles at pc 0x10
        PCWr = 1'b0; IF_ID_Wr = 1'b0;
        step(); chk_real("stall1", 32'hC, 32'h10);
        step(); chk_real("stall2", 32'hC, 32'h10);
        step(); chk_real("stall3", 32'hC, 32'h10);
        PCWr = 1'b1; IF_ID_Wr = 1'b1;
        step(); chk_real("release", 32'h10, 32'h14);

        // 3: flush while stalled, low address bits dropped
        PCWr = 1'b0; IF_ID_Wr = 1'b0; flush = 1'b1; target_pc = 32'h103;
        step();
        chk_bubble("flush", 32'h100);
        chk("flush_ifpc", IF_ID_PC, 32'h10);
        flush = 1'b0; PCWr = 1'b1; IF_ID_Wr = 1'b1;
        step(); chk_real("post_flush", 32'h100, 32'h104);

        // 4: imem miss for two cycles at 0x20
        flush = 1'b1; target_pc = 32'h20;
        step(); chk_bubble("redir20", 32'h20);
        flush = 1'b0; imem_valid = 1'b0;
        step(); chk_bubble("miss1", 32'h20);
        step(); chk_bubble("miss2", 32'h20);
        chk("miss_req", {31'd0, imem_req}, 32'd1);
        imem_valid = 1'b1;
        step(); chk_real("miss_done", 32'h20, 32'h24);

        // PCWr=1/IF_ID_Wr=0 holds; PCWr=0/IF_ID_Wr=1 bubbles
        IF_ID_Wr = 1'b0;
        step(); chk_real("hold_ifid", 32'h20, 32'h24);
        PCWr = 1'b0; IF_ID_Wr = 1'b1;
        step(); chk_bubble("pc_hold_bubble", 32'h24);
        PCWr = 1'b1;

        // 5: PC wrap, then reset in the middle of a miss
        flush = 1'b1; target_pc = 32'hFFFF_FFFF;
        step(); chk_bubble("redir_top", 32'hFFFF_FFFC);
        flush = 1'b0;
        step(); chk_real("wrap", 32'hFFFF_FFFC, 32'h0);
        flush = 1'b1; target_pc = 32'h40;
        step(); chk_bubble("redir40", 32'h40);
        flush = 1'b0; imem_valid = 1'b0;
        step(); chk_bubble("miss40a", 32'h40);
        step(); chk_bubble("miss40b", 32'h40);
        rst = 1'b1;
        step();
        chk_bubble("rst_miss", 32'h0);
        chk("rst_miss_req", {31'd0, imem_req}, 32'd0);
        chk("rst_miss_ifpc", IF_ID_PC, 32'h0);
        rst = 1'b0; imem_valid = 1'b1;
        step(); chk_bubble("reboot", 32'h0);
        step(); chk_real("refetch", 32'h0, 32'h4);

`ifdef FETCH_PERF_CNT_EN
        // 6: counters after a clean reset: three stalls and one flush
        rst = 1'b1;
        step();
        chk("perf_rst", perf_stall_cnt | perf_flush_cnt | perf_miss_cnt, 32'h0);
        rst = 1'b0;
        step();
        PCWr = 1'b0; IF_ID_Wr = 1'b0;
        step(); step(); step();
        flush = 1'b1; target_pc = 32'h80;
        step();
        flush = 1'b0;
        chk("perf_stall", perf_stall_cnt, 32'd3);
        chk("perf_flush", perf_flush_cnt, 32'd1);
        chk("perf_miss",  perf_miss_cnt,  32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
